// File: rtl/button_cond_pkg.sv
// Shared types and helpers for the pushbutton conditioning stage.
//   state_e   : debounce FSM state encoding
//   cnt_width : bit width of a counter that must hold 0..max_val
//   max_u     : larger of two unsigned values
package button_cond_pkg;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_DEB_PRESS   = 2'd1,
    ST_HELD        = 2'd2,
    ST_DEB_RELEASE = 2'd3
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer for asynchronous board inputs.
//   clk : destination clock
//   rst : asynchronous active-high reset, clears both stages
//   d   : asynchronous input
//   q   : input synchronized to clk (two cycles of latency)
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  // Two back-to-back stages give the first one a full cycle to resolve.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/button_step_conditioner.sv
// Turns a raw bouncing pushbutton into clean single-cycle step strobes,
// with optional auto-repeat while the button is held.
//   clk           : system clock
//   rst           : asynchronous active-high reset
//   btn_raw       : raw asynchronous pushbutton, active-high
//   step_pulse    : one-cycle strobe per accepted press or repeat
//   btn_level     : debounced button level
//   repeat_active : auto-repeat has fired during the current hold
module button_step_conditioner
  import button_cond_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 500000,
  parameter int unsigned REP_DELAY  = 25000000,
  parameter int unsigned REP_PERIOD = 5000000,
  parameter bit          REPEAT_EN  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic step_pulse,
  output logic btn_level,
  output logic repeat_active
);

  localparam int unsigned DEB_W = cnt_width(DEB_CYCLES);
  localparam int unsigned REP_W = cnt_width(max_u(REP_DELAY, REP_PERIOD));

  localparam logic [DEB_W-1:0] DEB_LAST        = DEB_W'(DEB_CYCLES - 1);
  localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REP_DELAY - 1);
  localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REP_PERIOD - 1);

  logic             btn_sync;
  state_e           state_q, state_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             first_done_q, first_done_d;
  logic             step_pulse_q, step_pulse_d;
  logic             btn_level_q, btn_level_d;
  logic             repeat_active_q, repeat_active_d;
  logic [REP_W-1:0] rep_target_c;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_raw),
    .q   (btn_sync)
  );

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      deb_cnt_q       <= '0;
      rep_cnt_q       <= '0;
      first_done_q    <= 1'b0;
      step_pulse_q    <= 1'b0;
      btn_level_q     <= 1'b0;
      repeat_active_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      deb_cnt_q       <= deb_cnt_d;
      rep_cnt_q       <= rep_cnt_d;
      first_done_q    <= first_done_d;
      step_pulse_q    <= step_pulse_d;
      btn_level_q     <= btn_level_d;
      repeat_active_q <= repeat_active_d;
    end
  end

  // Next-state, counters and registered-output inputs.
  always_comb begin
    state_d      = state_q;
    deb_cnt_d    = deb_cnt_q;
    rep_cnt_d    = rep_cnt_q;
    first_done_d = first_done_q;
    step_pulse_d = 1'b0;
    rep_target_c = first_done_q ? REP_PERIOD_LAST : REP_DELAY_LAST;

    case (state_q)
      ST_IDLE: begin
        if (btn_sync) begin
          state_d   = ST_DEB_PRESS;
          deb_cnt_d = '0;
        end
      end
      ST_DEB_PRESS: begin
        if (!btn_sync) begin
          state_d = ST_IDLE;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d      = ST_HELD;
          step_pulse_d = 1'b1;
          rep_cnt_d    = '0;
          first_done_d = 1'b0;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      ST_HELD: begin
        if (!btn_sync) begin
          state_d   = ST_DEB_RELEASE;
          deb_cnt_d = '0;
        end else if (REPEAT_EN && (rep_cnt_q == rep_target_c)) begin
          step_pulse_d = 1'b1;
          rep_cnt_d    = '0;
          first_done_d = 1'b1;
        end else if (rep_cnt_q != '1) begin
          // Saturate so a long hold with repeat disabled never wraps.
          rep_cnt_d = rep_cnt_q + REP_W'(1);
        end
      end
      ST_DEB_RELEASE: begin
        // rep_cnt is frozen here so a short release glitch only delays repeats.
        if (btn_sync) begin
          state_d = ST_HELD;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d      = ST_IDLE;
          first_done_d = 1'b0;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    btn_level_d     = (state_d == ST_HELD) || (state_d == ST_DEB_RELEASE);
    repeat_active_d = btn_level_d && first_done_d;
  end

  assign step_pulse    = step_pulse_q;
  assign btn_level     = btn_level_q;
  assign repeat_active = repeat_active_q;

endmodule

// File: tb/tb_button_step_conditioner.sv
// Bench for button_step_conditioner: two instances (repeat on / repeat off)
// share one button; a behavioural model is compared every cycle and
// directed phases pin literal edge numbers.
module tb_button_step_conditioner;

  localparam int DEB = 4;
  localparam int DEL = 8;
  localparam int PER = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_raw = 1'b0;

  logic rep_step, rep_lvl, rep_ract;
  logic one_step, one_lvl, one_ract;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  button_step_conditioner #(
    .DEB_CYCLES(DEB), .REP_DELAY(DEL), .REP_PERIOD(PER), .REPEAT_EN(1'b1)
  ) dut_rep (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .step_pulse(rep_step), .btn_level(rep_lvl), .repeat_active(rep_ract)
  );

  button_step_conditioner #(
    .DEB_CYCLES(DEB), .REP_DELAY(DEL), .REP_PERIOD(PER), .REPEAT_EN(1'b0)
  ) dut_one (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .step_pulse(one_step), .btn_level(one_lvl), .repeat_active(one_ract)
  );

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b want %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model. Index 0 = repeat enabled, 1 = repeat disabled.
  // run   : consecutive edges the FSM saw the input opposite to the accepted level
  // since : edges spent held-and-pressed since the last strobe
  bit m_s1, m_s2, seen;
  bit m_level[2];
  bit m_first[2];
  bit m_pulse[2];
  int m_run[2];
  int m_since[2];

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_s1 = 1'b0;
        m_s2 = 1'b0;
        for (int i = 0; i < 2; i++) begin
          m_level[i] = 1'b0; m_first[i] = 1'b0; m_pulse[i] = 1'b0;
          m_run[i] = 0; m_since[i] = 0;
        end
      end else begin
        seen = m_s2;
        m_s2 = m_s1;
        m_s1 = btn_raw;
        for (int i = 0; i < 2; i++) begin
          m_pulse[i] = 1'b0;
          if (!m_level[i]) begin
            if (seen) begin
              m_run[i]++;
              if (m_run[i] == DEB + 1) begin
                m_level[i] = 1'b1; m_pulse[i] = 1'b1;
                m_since[i] = 0; m_first[i] = 1'b0; m_run[i] = 0;
              end
            end else begin
              m_run[i] = 0;
            end
          end else if (!seen) begin
            m_run[i]++;
            if (m_run[i] == DEB + 1) begin
              m_level[i] = 1'b0; m_first[i] = 1'b0; m_run[i] = 0;
            end
          end else if (m_run[i] > 0) begin
            m_run[i] = 0;
          end else begin
            m_since[i]++;
            if (i == 0 && m_since[i] == (m_first[i] ? PER : DEL)) begin
              m_pulse[i] = 1'b1; m_since[i] = 0; m_first[i] = 1'b1;
            end
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("cmp_rep_step", rep_step, m_pulse[0]);
      check("cmp_rep_level", rep_lvl, m_level[0]);
      check("cmp_rep_ract", rep_ract, m_level[0] & m_first[0]);
      check("cmp_one_step", one_step, m_pulse[1]);
      check("cmp_one_level", one_lvl, m_level[1]);
      check("cmp_one_ract", one_ract, m_level[1] & m_first[1]);
    end
  end

  task automatic check_zero(input string name);
    check({name, "_rep_step"}, rep_step, 1'b0);
    check({name, "_rep_level"}, rep_lvl, 1'b0);
    check({name, "_rep_ract"}, rep_ract, 1'b0);
    check({name, "_one_step"}, one_step, 1'b0);
    check({name, "_one_level"}, one_lvl, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    btn_raw = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Bit e of each mask describes edge e (1-based) counted from reset release:
  // btn_m is the button level sampled at that edge, the others the outputs just after it.
  task automatic run_phase(input string name, input int n, input logic [31:0] btn_m,
                           input logic [31:0] p_rep, input logic [31:0] p_one,
                           input logic [31:0] lvl, input logic [31:0] ract);
    do_reset();
    btn_raw = btn_m[1];
    for (int e = 1; e <= n; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s_rep_step_e%0d", name, e), rep_step, p_rep[e]);
      check($sformatf("%s_one_step_e%0d", name, e), one_step, p_one[e]);
      check($sformatf("%s_level_e%0d", name, e), rep_lvl, lvl[e]);
      check($sformatf("%s_ract_e%0d", name, e), rep_ract, ract[e]);
      btn_raw = btn_m[e+1];
    end
  endtask

  // Counts edges after reset release until the first strobe, bounded.
  task automatic wait_pulse(input string name, input int exp_e);
    int got;
    got = -1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      #1;
      if (rep_step === 1'b1) begin
        got = e;
        check({name, "_one_step"}, one_step, 1'b1);
        break;
      end
    end
    check_int({name, "_edge"}, got, exp_e);
  endtask

  initial begin
    #1;
    check_zero("reset_state");

    // Clean press: high for edges 1..11.
    run_phase("clean", 20, 32'h0000_0FFE, 32'h0000_0080, 32'h0000_0080,
              32'h0003_FF80, 32'h0000_0000);

    // Bounce: 2 high / 2 low, five times.
    run_phase("bounce", 24, 32'h0006_6666, 32'h0, 32'h0, 32'h0, 32'h0);

    // Long hold for 25 edges.
    run_phase("hold", 25, 32'h03FF_FFFE, 32'h0124_8080, 32'h0000_0080,
              32'h03FF_FF80, 32'h03FF_8000);

    // Async reset while held with repeat active, button still pressed.
    btn_raw = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_zero("rst_async_held");
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check_zero($sformatf("rst_hold_c%0d", k));
    end
    @(negedge clk);
    #1;
    rst = 1'b0;
    wait_pulse("rst_release", 7);

    // Release glitch: input low only at edge 10.
    run_phase("glitch", 24, 32'h01FF_FBFE, 32'h0092_0080, 32'h0000_0080,
              32'h01FF_FF80, 32'h01FE_0000);

    // Reset between edges 5 and 6 of a press.
    do_reset();
    btn_raw = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_zero("rst_mid_deb");
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    wait_pulse("rst_mid_release", 7);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
